// File: rtl/lsu_bus_master.sv
// Load/store bus initiator: turns one core byte/half/word access into one or two aligned bus beats.
// Optional macro LSU_MISALIGN_TRAP_EN: misaligned (split) accesses return an error instead of splitting.
`timescale 1ns/1ps

module lsu_bus_master #(
    parameter int ADDR_W  = 32,
    parameter int BEAT_TO = 0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [1:0]        req_size_i,
    input  logic              req_unsigned_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [31:0]       req_wdata_i,
    output logic              rsp_valid_o,
    output logic [31:0]       rsp_rdata_o,
    output logic              rsp_err_o,
    output logic              bus_valid_o,
    input  logic              bus_ready_i,
    output logic              bus_we_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [3:0]        bus_be_o,
    output logic [31:0]       bus_wdata_o,
    input  logic [31:0]       bus_rdata_i
);

    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;

    localparam int CNT_W = (BEAT_TO > 2) ? $clog2(BEAT_TO) : 1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((BEAT_TO > 0) ? BEAT_TO - 1 : 0);

`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    state_t            state_q;
    logic [1:0]        off_q;
    logic [1:0]        size_q;
    logic              uns_q;
    logic              split_q;
    logic [3:0]        be1_q;
    logic [31:0]       wd1_q;
    logic [31:0]       lo_q;
    logic [CNT_W-1:0]  cnt_q;

    logic [1:0]        off;
    logic [3:0]        mask;
    logic [7:0]        be_w;
    logic [63:0]       wd_w;
    logic              split;
    logic              trap;
    logic              timeout;

    // Shift right-justified data and lane mask by the byte offset; the upper half feeds beat 1.
    always_comb begin
        off = req_addr_i[1:0];
        case (req_size_i)
            2'b00:   mask = 4'h1;
            2'b01:   mask = 4'h3;
            2'b10:   mask = 4'hF;
            default: mask = 4'h0;
        endcase
        be_w    = {4'b0000, mask} << off;
        wd_w    = {32'b0, req_wdata_i} << {off, 3'b000};
        split   = (req_size_i == 2'b10 && off != 2'b00) || (req_size_i == 2'b01 && off == 2'b11);
        trap    = (req_size_i == 2'b11) || (TRAP_EN && split);
        timeout = (BEAT_TO != 0) && !bus_ready_i && (cnt_q == TO_LAST);
    end

    function automatic logic [31:0] load_ext(input logic [63:0] d, input logic [1:0] off_v,
                                             input logic [1:0] size_v, input logic uns_v);
        logic [31:0]        sh;
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic [31:0]        r;
        sh = 32'(d >> {off_v, 3'b000});
        b  = sh[7:0];
        h  = sh[15:0];
        case (size_v)
            2'b00: if (uns_v) r = 32'(sh[7:0]);  else r = 32'(b);
            2'b01: if (uns_v) r = 32'(sh[15:0]); else r = 32'(h);
            default: r = sh;
        endcase
        return r;
    endfunction

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            req_ready_o <= 1'b1;
            rsp_valid_o <= 1'b0;
            rsp_rdata_o <= '0;
            rsp_err_o   <= 1'b0;
            bus_valid_o <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_addr_o  <= '0;
            bus_be_o    <= '0;
            bus_wdata_o <= '0;
            off_q       <= '0;
            size_q      <= '0;
            uns_q       <= 1'b0;
            split_q     <= 1'b0;
            be1_q       <= '0;
            wd1_q       <= '0;
            lo_q        <= '0;
            cnt_q       <= '0;
        end else begin
            case (state_q)
                IDLE: if (req_valid_i) begin
                    req_ready_o <= 1'b0;
                    off_q       <= off;
                    size_q      <= req_size_i;
                    uns_q       <= req_unsigned_i;
                    split_q     <= split;
                    bus_we_o    <= req_we_i;
                    rsp_rdata_o <= '0;
                    if (trap) begin
                        state_q     <= RESP;
                        rsp_valid_o <= 1'b1;
                        rsp_err_o   <= 1'b1;
                    end else begin
                        state_q     <= BEAT0;
                        bus_valid_o <= 1'b1;
                        bus_addr_o  <= {req_addr_i[ADDR_W-1:2], 2'b00};
                        bus_be_o    <= be_w[3:0];
                        bus_wdata_o <= wd_w[31:0];
                        be1_q       <= be_w[7:4];
                        wd1_q       <= wd_w[63:32];
                        cnt_q       <= '0;
                    end
                end
                BEAT0, BEAT1: begin
                    if (bus_ready_i) begin
                        cnt_q <= '0;
                        if (state_q == BEAT0 && split_q) begin
                            // Address wraps naturally past the top of the address space.
                            state_q     <= BEAT1;
                            lo_q        <= bus_rdata_i;
                            bus_addr_o  <= bus_addr_o + ADDR_W'(4);
                            bus_be_o    <= be1_q;
                            bus_wdata_o <= wd1_q;
                        end else begin
                            state_q     <= RESP;
                            bus_valid_o <= 1'b0;
                            rsp_valid_o <= 1'b1;
                            rsp_err_o   <= 1'b0;
                            rsp_rdata_o <= bus_we_o ? 32'h0 :
                                load_ext(split_q ? {bus_rdata_i, lo_q} : {32'h0, bus_rdata_i},
                                         off_q, size_q, uns_q);
                        end
                    end else if (timeout) begin
                        state_q     <= RESP;
                        bus_valid_o <= 1'b0;
                        rsp_valid_o <= 1'b1;
                        rsp_err_o   <= 1'b1;
                        rsp_rdata_o <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                RESP: begin
                    state_q     <= IDLE;
                    rsp_valid_o <= 1'b0;
                    req_ready_o <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_bus_master.sv
// Bench for lsu_bus_master: directed vector table, reset-mid-op sequence, randomized ops vs byte-memory model.
`timescale 1ns/1ps

module tb_lsu_bus_master;

`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic        req_we_i = 1'b0;
    logic [1:0]  req_size_i = 2'b00;
    logic        req_unsigned_i = 1'b0;
    logic [31:0] req_addr_i = '0;
    logic [31:0] req_wdata_i = '0;
    logic        rsp_valid_o;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic        bus_valid_o;
    logic        bus_ready_i = 1'b0;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [3:0]  bus_be_o;
    logic [31:0] bus_wdata_o;
    logic [31:0] bus_rdata_i = '0;

    int errors = 0;
    int checks = 0;

    lsu_bus_master #(.ADDR_W(32), .BEAT_TO(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
        .req_size_i(req_size_i), .req_unsigned_i(req_unsigned_i), .req_addr_i(req_addr_i),
        .req_wdata_i(req_wdata_i), .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o),
        .rsp_err_o(rsp_err_o), .bus_valid_o(bus_valid_o), .bus_ready_i(bus_ready_i),
        .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o), .bus_be_o(bus_be_o),
        .bus_wdata_o(bus_wdata_o), .bus_rdata_i(bus_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic we; logic [1:0] size; logic uns; logic [31:0] addr, wdata, rd0, rd1; int st0, st1;
        logic [31:0] e_rdata; logic e_err; int e_beats, e_lat;
        logic [31:0] e_a0; logic [3:0] e_be0; logic [31:0] e_wd0;
        logic [31:0] e_a1; logic [3:0] e_be1; logic [31:0] e_wd1;
    } vec_t;

    typedef struct {
        logic done; logic [31:0] rdata; logic err; int lat; int beats;
        logic [31:0] a0, a1, wd0, wd1; logic [3:0] be0, be1; logic we0;
    } res_t;

    vec_t vecs[$];
    logic [31:0] rmem[bit [31:0]];
    logic [7:0]  mb[bit [31:0]];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] init_word(input logic [31:0] w);
        return (w * 32'h9E3779B1) ^ 32'h5A5A5A5A;
    endfunction

    function automatic logic [31:0] rword(input logic [31:0] w);
        return rmem.exists(w) ? rmem[w] : init_word(w);
    endfunction

    function automatic logic [7:0] mbyte(input logic [31:0] a);
        logic [31:0] t;
        if (mb.exists(a)) return mb[a];
        t = init_word({a[31:2], 2'b00});
        return t[8*int'(a[1:0]) +: 8];
    endfunction

    task automatic bus_write(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
        logic [31:0] w;
        w = rword(a);
        for (int l = 0; l < 4; l++) if (be[l]) w[8*l +: 8] = d[8*l +: 8];
        rmem[a] = w;
    endtask

    function automatic vec_t mk(input logic we, input logic [1:0] size, input logic uns,
        input logic [31:0] addr, wdata, rd0, rd1, input int st0, st1,
        input logic [31:0] e_rdata, input logic e_err, input int e_beats, e_lat,
        input logic [31:0] e_a0, input logic [3:0] e_be0, input logic [31:0] e_wd0,
        input logic [31:0] e_a1, input logic [3:0] e_be1, input logic [31:0] e_wd1);
        vec_t v;
        v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
        v.rd0 = rd0; v.rd1 = rd1; v.st0 = st0; v.st1 = st1;
        v.e_rdata = e_rdata; v.e_err = e_err; v.e_beats = e_beats; v.e_lat = e_lat;
        v.e_a0 = e_a0; v.e_be0 = e_be0; v.e_wd0 = e_wd0;
        v.e_a1 = e_a1; v.e_be1 = e_be1; v.e_wd1 = e_wd1;
        return v;
    endfunction

    // Issue one request at a negedge and follow it to its response; returns at a negedge.
    task automatic run_op(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata, input logic directed,
                          input logic [31:0] rd0, input logic [31:0] rd1,
                          input int st0, input int st1, output res_t r);
        int stall;
        int bidx;
        int st;
        r = '{default: 0};
        stall = 0;
        bidx = 0;
        chk("ready_idle", 32'(req_ready_o), 32'd1);
        req_valid_i = 1'b1; req_we_i = we; req_size_i = size; req_unsigned_i = uns;
        req_addr_i = addr; req_wdata_i = wdata; bus_ready_i = 1'b0;
        @(posedge clk_i);
        @(negedge clk_i);
        req_valid_i = 1'b0;
        req_we_i = 1'($urandom); req_size_i = 2'($urandom); req_unsigned_i = 1'($urandom);
        req_addr_i = $urandom; req_wdata_i = $urandom;
        for (int k = 1; k <= 40 && !r.done; k++) begin
            if (rsp_valid_o) begin
                r.done = 1'b1; r.lat = k; r.rdata = rsp_rdata_o; r.err = rsp_err_o;
                bus_ready_i = 1'b0;
            end else begin
                if (bus_valid_o) begin
                    st = (bidx == 0) ? st0 : st1;
                    if (stall >= st) begin
                        bus_ready_i = 1'b1;
                        stall = 0;
                        if (bidx == 0) begin
                            r.a0 = bus_addr_o; r.be0 = bus_be_o; r.wd0 = bus_wdata_o; r.we0 = bus_we_o;
                        end else begin
                            r.a1 = bus_addr_o; r.be1 = bus_be_o; r.wd1 = bus_wdata_o;
                        end
                        if (directed) begin
                            bus_rdata_i = (bidx == 0) ? rd0 : rd1;
                        end else begin
                            chk("beat_aligned", 32'(bus_addr_o[1:0]), 32'd0);
                            if (bus_we_o) begin
                                bus_write(bus_addr_o, bus_be_o, bus_wdata_o);
                                bus_rdata_i = $urandom;
                            end else begin
                                bus_rdata_i = rword(bus_addr_o);
                            end
                        end
                        bidx++;
                    end else begin
                        bus_ready_i = 1'b0;
                        bus_rdata_i = $urandom;
                        stall++;
                    end
                end else begin
                    bus_ready_i = 1'b0;
                end
                @(negedge clk_i);
            end
        end
        r.beats = bidx;
        if (!r.done) begin
            checks++;
            errors++;
            $display("FAIL op_done: no response within 40 cycles, expected one");
        end else begin
            chk("ready_in_resp", 32'(req_ready_o), 32'd0);
            req_valid_i = 1'b1; req_we_i = 1'b0; req_size_i = 2'b10; req_addr_i = 32'h40;
            @(negedge clk_i);
            chk("rsp_one_pulse", 32'(rsp_valid_o), 32'd0);
            chk("no_accept_in_resp", 32'(bus_valid_o), 32'd0);
            chk("ready_after_resp", 32'(req_ready_o), 32'd1);
            req_valid_i = 1'b0;
        end
    endtask

    initial begin
        res_t r;
        vec_t v;
        bit   saw_rsp;

        // Reset state
        @(negedge clk_i);
        @(negedge clk_i);
        chk("rst_req_ready", 32'(req_ready_o), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata_o, 32'd0);
        chk("rst_rsp_err", 32'(rsp_err_o), 32'd0);
        chk("rst_bus_valid", 32'(bus_valid_o), 32'd0);
        chk("rst_bus_we", 32'(bus_we_o), 32'd0);
        chk("rst_bus_addr", bus_addr_o, 32'd0);
        chk("rst_bus_be", 32'(bus_be_o), 32'd0);
        chk("rst_bus_wdata", bus_wdata_o, 32'd0);
        rst_i = 1'b0;
        @(negedge clk_i);

        // we size uns addr wdata rd0 rd1 st0 st1 | rdata err beats lat | a0 be0 wd0 | a1 be1 wd1
        vecs.push_back(mk(0, 2, 0, 32'h10, 0, 32'hDEADBEEF, 0, 0, 0, 32'hDEADBEEF, 0, 1, 2, 32'h10, 4'hF, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 32'h13, 0, 32'h80123456, 0, 0, 0, 32'hFFFFFF80, 0, 1, 2, 32'h10, 4'h8, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 32'h13, 0, 32'h80123456, 0, 0, 0, 32'h00000080, 0, 1, 2, 32'h10, 4'h8, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 32'h02, 32'h0000ABCD, 0, 0, 0, 0, 0, 0, 1, 2, 32'h00, 4'hC, 32'hABCD0000, 0, 0, 0));
        vecs.push_back(mk(1, 2, 0, 32'h0E, 32'h11223344, 0, 0, 0, 0, 0, 0, 2, 3, 32'h0C, 4'hC, 32'h33440000, 32'h10, 4'h3, 32'h00001122));
        vecs.push_back(mk(0, 2, 0, 32'hFFFFFFFE, 0, 32'hAABB1234, 32'h5678CCDD, 0, 0, 32'hCCDDAABB, 0, 2, 3, 32'hFFFFFFFC, 4'hC, 0, 32'h0, 4'h3, 0));
        vecs.push_back(mk(0, 3, 0, 32'h20, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 32'h03, 0, 32'h9A000000, 32'h000000BC, 0, 0, 32'hFFFFBC9A, 0, 2, 3, 32'h0, 4'h8, 0, 32'h4, 4'h1, 0));
        vecs.push_back(mk(0, 1, 1, 32'h01, 0, 32'h00F00D00, 0, 0, 0, 32'h0000F00D, 0, 1, 2, 32'h0, 4'h6, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 32'h01, 32'h000000A5, 0, 0, 0, 0, 0, 0, 1, 2, 32'h0, 4'h2, 32'h0000A500, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 32'h02, 0, 32'h80010000, 0, 0, 0, 32'hFFFF8001, 0, 1, 2, 32'h0, 4'hC, 0, 0, 0, 0));
        vecs.push_back(mk(0, 2, 0, 32'h10, 0, 32'hCAFEF00D, 0, 3, 0, 32'hCAFEF00D, 0, 1, 5, 32'h10, 4'hF, 0, 0, 0, 0));
        vecs.push_back(mk(0, 2, 0, 32'h24, 0, 32'h12345678, 0, 99, 0, 0, 1, 0, 5, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 2, 0, 32'h0E, 32'h11223344, 0, 0, 1, 99, 0, 1, 1, 7, 32'h0C, 4'hC, 32'h33440000, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 32'h03, 32'h0000BEEF, 0, 0, 0, 0, 0, 0, 2, 3, 32'h0, 4'h8, 32'hEF000000, 32'h4, 4'h1, 32'h000000BE));

        for (int i = 0; i < vecs.size(); i++) begin
            if (TRAP && vecs[i].size != 2'b11 && (int'(vecs[i].addr[1:0]) + (1 << vecs[i].size)) > 4) begin
                vecs[i].e_err = 1'b1; vecs[i].e_rdata = 0; vecs[i].e_beats = 0; vecs[i].e_lat = 1;
            end
        end

        foreach (vecs[i]) begin
            v = vecs[i];
            run_op(v.we, v.size, v.uns, v.addr, v.wdata, 1'b1, v.rd0, v.rd1, v.st0, v.st1, r);
            chk($sformatf("v%0d_err", i), 32'(r.err), 32'(v.e_err));
            chk($sformatf("v%0d_rdata", i), r.rdata, v.e_rdata);
            chk($sformatf("v%0d_beats", i), 32'(r.beats), 32'(v.e_beats));
            chk($sformatf("v%0d_latency", i), 32'(r.lat), 32'(v.e_lat));
            if (v.e_beats >= 1) begin
                chk($sformatf("v%0d_addr0", i), r.a0, v.e_a0);
                chk($sformatf("v%0d_be0", i), 32'(r.be0), 32'(v.e_be0));
                chk($sformatf("v%0d_we0", i), 32'(r.we0), 32'(v.we));
                if (v.we) chk($sformatf("v%0d_wdata0", i), r.wd0, v.e_wd0);
            end
            if (v.e_beats == 2) begin
                chk($sformatf("v%0d_addr1", i), r.a1, v.e_a1);
                chk($sformatf("v%0d_be1", i), 32'(r.be1), 32'(v.e_be1));
                if (v.we) chk($sformatf("v%0d_wdata1", i), r.wd1, v.e_wd1);
            end
        end

        // Reset in the middle of a stalled beat
        req_valid_i = 1'b1; req_we_i = 1'b0; req_size_i = 2'b10; req_addr_i = 32'h20;
        bus_ready_i = 1'b0;
        @(negedge clk_i);
        req_valid_i = 1'b0;
        chk("midrst_beat_up", 32'(bus_valid_o), 32'd1);
        repeat (3) @(negedge clk_i);
        #2 rst_i = 1'b1;
        #1;
        chk("midrst_bus_valid_async", 32'(bus_valid_o), 32'd0);
        chk("midrst_ready", 32'(req_ready_o), 32'd1);
        @(negedge clk_i);
        rst_i = 1'b0;
        saw_rsp = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk_i);
            if (rsp_valid_o || bus_valid_o) saw_rsp = 1'b1;
        end
        chk("midrst_no_rsp", 32'(saw_rsp), 32'd0);

        // Randomized accesses against a byte-addressed memory model
        for (int i = 0; i < 300; i++) begin
            logic        we, uns;
            logic [1:0]  size;
            logic [31:0] addr, wdata, exp_rd;
            logic        exp_err;
            int          n, beats, st0, st1, exp_lat;
            we    = 1'($urandom);
            uns   = 1'($urandom);
            size  = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            addr  = ($urandom_range(0, 1) ? 32'h100 : 32'hFFFFFFE0) + 32'($urandom_range(0, 31));
            wdata = $urandom;
            st0   = $urandom_range(0, 3);
            st1   = $urandom_range(0, 3);
            n     = 1 << size;
            exp_rd = 0;
            beats = 0;
            if (size == 2'b11) begin
                exp_err = 1'b1; exp_lat = 1;
            end else begin
                beats = ((int'(addr[1:0]) + n) > 4) ? 2 : 1;
                if (TRAP && beats == 2) begin
                    exp_err = 1'b1; exp_lat = 1; beats = 0;
                end else begin
                    exp_err = 1'b0;
                    exp_lat = 1 + beats + st0 + ((beats == 2) ? st1 : 0);
                    if (we) begin
                        for (int j = 0; j < n; j++) mb[addr + 32'(j)] = wdata[8*j +: 8];
                    end else begin
                        for (int j = 0; j < n; j++) exp_rd = exp_rd | (32'(mbyte(addr + 32'(j))) << (8*j));
                        if (!uns && size == 2'b00) exp_rd = (exp_rd ^ 32'h80) - 32'h80;
                        if (!uns && size == 2'b01) exp_rd = (exp_rd ^ 32'h8000) - 32'h8000;
                    end
                end
            end
            run_op(we, size, uns, addr, wdata, 1'b0, 0, 0, st0, st1, r);
            chk($sformatf("r%0d_err", i), 32'(r.err), 32'(exp_err));
            chk($sformatf("r%0d_rdata", i), r.rdata, exp_rd);
            chk($sformatf("r%0d_latency", i), 32'(r.lat), 32'(exp_lat));
            chk($sformatf("r%0d_beats", i), 32'(r.beats), 32'(beats));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
